// File: rtl/simd_pkg.sv
// Shared SIMD datapath definitions: lane geometry defaults, serializer FSM
// encoding and a lane index width helper.
package simd_pkg;

    localparam int SIMD_LANES  = 4;
    localparam int SIMD_LANE_W = 16;

    typedef logic [SIMD_LANE_W-1:0] lane_t;

    typedef enum logic {IDLE, SEND} serializer_state_t;

    // Index width for n lanes; a single-lane vector still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vector_lane_serializer_lane_select.sv
// Combinational LANES:1 mux picking one LANE_W-bit lane out of a packed vector.
module lane_select
    import simd_pkg::*;
#(
    parameter int LANES  = SIMD_LANES,
    parameter int LANE_W = SIMD_LANE_W,
    localparam int IDX_W = idx_width(LANES)
) (
    input  logic [LANES-1:0][LANE_W-1:0] vec_i,
    input  logic [IDX_W-1:0]             idx_i,
    output logic [LANE_W-1:0]            lane_o
);

    // Compare-and-select so out-of-range indices (non power-of-two LANES) give zero.
    always_comb begin
        lane_o = '0;
        for (int k = 0; k < LANES; k++) begin
            if (idx_i == IDX_W'(k)) lane_o = vec_i[k];
        end
    end

endmodule

// File: rtl/vector_lane_serializer.sv
// Captures a whole SIMD vector and streams it out one lane per beat, lane 0
// first. A reload on the last beat keeps back-to-back vectors bubble-free.
module vector_lane_serializer
    import simd_pkg::*;
#(
    parameter int LANES  = SIMD_LANES,
    parameter int LANE_W = SIMD_LANE_W,
    localparam int VEC_W = LANES * LANE_W,
    localparam int IDX_W = idx_width(LANES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [VEC_W-1:0]  load_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_lane,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    serializer_state_t               state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [LANES-1:0][LANE_W-1:0]    vec_q, vec_d;
    logic [LANE_W-1:0]               sel_lane;
    logic                            sending;
    logic                            is_last;

    assign sending = (state_q == SEND);
    assign is_last = sending && (idx_q == LAST_IDX);

    lane_select #(
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_lane_select (
        .vec_i  (vec_q),
        .idx_i  (idx_q),
        .lane_o (sel_lane)
    );

    // State, lane index and vector register; reset clears the held vector too.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
        end
    end

    // Next state: flush wins over any load/out fire; last beat may reload in place.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        if (flush) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        vec_d   = load_data;
                        idx_d   = '0;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (!is_last) begin
                            idx_d = idx_q + 1'b1;
                        end else if (load_valid) begin
                            vec_d = load_data;
                            idx_d = '0;
                        end else begin
                            state_d = IDLE;
                            idx_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Outputs: lane data is zeroed outside SEND; load_ready has a comb path from out_ready.
    always_comb begin
        out_valid  = sending;
        busy       = sending;
        out_last   = is_last;
        out_idx    = idx_q;
        out_lane   = sending ? sel_lane : '0;
        load_ready = !rst && !flush && ((state_q == IDLE) || (is_last && out_ready));
    end

endmodule

// File: tb/tb_vector_lane_serializer.sv
// Scoreboard bench for vector_lane_serializer: a 4x16 instance for drain,
// backpressure, back-to-back, flush and reset cases, and a 1x8 instance for
// the single-lane corner.
module tb_vector_lane_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        lv, lr, fl, ov, ordy, olast, busy;
    logic [63:0] ld;
    logic [15:0] olane;
    logic [1:0]  oidx;

    logic        lv1, lr1, fl1, ov1, ordy1, olast1, busy1;
    logic [7:0]  ld1;
    logic [7:0]  olane1;
    logic [0:0]  oidx1;

    vector_lane_serializer #(.LANES(4), .LANE_W(16)) u4 (
        .clk(clk), .rst(rst), .load_valid(lv), .load_ready(lr), .load_data(ld),
        .flush(fl), .out_valid(ov), .out_ready(ordy), .out_lane(olane),
        .out_idx(oidx), .out_last(olast), .busy(busy)
    );

    vector_lane_serializer #(.LANES(1), .LANE_W(8)) u1 (
        .clk(clk), .rst(rst), .load_valid(lv1), .load_ready(lr1), .load_data(ld1),
        .flush(fl1), .out_valid(ov1), .out_ready(ordy1), .out_lane(olane1),
        .out_idx(oidx1), .out_last(olast1), .busy(busy1)
    );

    typedef struct {
        logic [15:0] lane;
        logic [1:0]  idx;
        logic        last;
    } beat_t;

    beat_t sb[$];
    beat_t sb1[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_vec(input logic [63:0] v);
        for (int k = 0; k < 4; k++) begin
            beat_t b;
            b.lane = v[k*16 +: 16];
            b.idx  = 2'(k);
            b.last = (k == 3);
            sb.push_back(b);
        end
    endtask

    task automatic push1(input logic [7:0] v);
        beat_t b;
        b.lane = {8'h00, v};
        b.idx  = 2'd0;
        b.last = 1'b1;
        sb1.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare every accepted beat of the 4-lane instance against the scoreboard.
    always @(negedge clk) begin
        if (!rst && !fl && ov && ordy) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                beat_t b;
                b = sb.pop_front();
                chk("beat_lane", olane, b.lane);
                chk("beat_idx",  oidx,  b.idx);
                chk("beat_last", olast, b.last);
            end
        end
    end

    // Same for the single-lane instance.
    always @(negedge clk) begin
        if (!rst && !fl1 && ov1 && ordy1) begin
            if (sb1.size() == 0) chk("sb1_underflow", 1, 0);
            else begin
                beat_t b;
                b = sb1.pop_front();
                chk("l1_lane", olane1, b.lane[7:0]);
                chk("l1_idx",  oidx1,  b.idx[0]);
                chk("l1_last", olast1, b.last);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    localparam logic [63:0] V1 = 64'h4444_3333_2222_1111;
    localparam logic [63:0] V2 = 64'hDDDD_CCCC_BBBB_AAAA;

    initial begin
        rst = 1; lv = 0; ld = '0; fl = 0; ordy = 0;
        lv1 = 0; ld1 = '0; fl1 = 0; ordy1 = 0;
        tick(); tick();
        chk("rst_load_ready", lr, 0);
        chk("rst_out_valid", ov, 0);
        rst = 0;
        #1;
        chk("por_out_valid", ov, 0);
        chk("por_out_lane", olane, 0);
        chk("por_out_idx", oidx, 0);
        chk("por_out_last", olast, 0);
        chk("por_busy", busy, 0);
        chk("por_load_ready", lr, 1);
        chk("por_load_ready1", lr1, 1);

        // Basic drain
        ld = V1; lv = 1; ordy = 1; push_vec(V1);
        tick(); lv = 0;
        for (int k = 0; k < 4; k++) begin
            chk("drain_valid", ov, 1);
            chk("drain_last", olast, k == 3);
            tick();
        end
        chk("drain_idle_busy", busy, 0);
        chk("drain_idle_valid", ov, 0);

        // Backpressure at idx 1
        ld = V1; lv = 1; push_vec(V1);
        tick(); lv = 0;
        tick();
        ordy = 0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_lane", olane, 16'h2222);
            chk("bp_hold_idx", oidx, 1);
            chk("bp_hold_valid", ov, 1);
            tick();
        end
        ordy = 1;
        tick();
        chk("bp_resume", olane, 16'h3333);
        tick(); tick();
        chk("bp_idle", busy, 0);

        // Back-to-back vectors
        ld = V1; lv = 1; push_vec(V1);
        tick(); lv = 0;
        for (int k = 0; k < 8; k++) begin
            chk("b2b_valid", ov, 1);
            if (k == 3) begin
                ld = V2; lv = 1; push_vec(V2);
                #1;
                chk("b2b_load_ready", lr, 1);
            end
            tick(); lv = 0;
        end
        chk("b2b_idle", ov, 0);

        // Flush at idx 2, with a load offered in the same cycle
        ld = V1; lv = 1; push_vec(V1);
        tick(); lv = 0;
        tick(); tick();
        chk("flush_at_idx", oidx, 2);
        fl = 1; lv = 1; ld = 64'hFFFF_FFFF_FFFF_FFFF; sb.delete();
        #1;
        chk("flush_load_ready", lr, 0);
        tick(); fl = 0; lv = 0;
        chk("flush_out_valid", ov, 0);
        chk("flush_busy", busy, 0);
        ld = '0; lv = 1; push_vec(64'h0);
        tick(); lv = 0;
        chk("flush_reload_valid", ov, 1);
        chk("flush_reload_idx", oidx, 0);
        tick(); tick(); tick(); tick();
        chk("flush_reload_idle", ov, 0);

        // Reset at idx 1
        ld = V1; lv = 1; push_vec(V1);
        tick(); lv = 0;
        tick();
        chk("rmid_at_idx", oidx, 1);
        rst = 1; sb.delete();
        #1;
        chk("rmid_load_ready_now", lr, 0);
        tick();
        chk("rmid_out_valid", ov, 0);
        chk("rmid_out_lane", olane, 0);
        chk("rmid_out_idx", oidx, 0);
        chk("rmid_out_last", olast, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_load_ready", lr, 0);
        rst = 0;
        #1;
        chk("rmid_load_ready_after", lr, 1);

        // Single-lane instance, two vectors back-to-back
        ld1 = 8'h5A; lv1 = 1; ordy1 = 1; push1(8'h5A);
        tick();
        ld1 = 8'hA5; push1(8'hA5);
        #1;
        chk("l1_load_ready", lr1, 1);
        chk("l1_valid0", ov1, 1);
        chk("l1_last0", olast1, 1);
        tick(); lv1 = 0;
        chk("l1_valid1", ov1, 1);
        chk("l1_last1", olast1, 1);
        chk("l1_idx1", oidx1, 0);
        tick();
        chk("l1_idle", ov1, 0);

        chk("sb_empty", sb.size(), 0);
        chk("sb1_empty", sb1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
